exerion_input_cond: RTL

- Conditions raw active-high MiSTer joystick bits into the active-low 9-bit CONTROLS bus consumed by exerion_fpga.
- Functions: synchronise, debounce, neutralise opposing directions, optional turbo on Fire, and a frame-timed coin pulse.
- Sits between the joystick_0 decode and the core CONTROLS input, in the clkm_20MHZ domain.
- Frame timing is derived from the core's vertical blank.

---
 rtl/exerion_input_cond.sv | 123 ++++++++++++
 1 files changed

// File: rtl/exerion_input_cond.sv
// exerion_input_cond: conditions raw joystick bits into the active-low Exerion CONTROLS bus
module exerion_input_cond #(
  parameter logic [15:0] DEB_CYC      = 16'd20000,
  parameter logic [3:0]  COIN_FRAMES  = 4'd3,
  parameter logic [3:0]  COIN_GAP     = 4'd4,
  parameter logic [2:0]  TURBO_FRAMES = 3'd2
) (
  input  logic       clkm_20MHZ,
  input  logic       RESET_n,
  input  logic [8:0] joy_in,
  input  logic       vblank,
  input  logic       pause,
  input  logic       turbo_en,
  output logic [8:0] CONTROLS,
  output logic       coin_busy
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_st_e;
  logic [8:0]  sync1_q, sync2_q, deb_q, deb_d;
  logic [15:0] cnt_q [9];
  logic [15:0] cnt_d [9];
  logic        vblank_q, frame_tick, turbo_wrap;
  logic [2:0]  tcnt_q, tcnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  ctl_q, ctl_d;
  coin_st_e    st_q;
  logic [3:0]  fcnt_q;
  logic        coin_q, coin_prev_q;
  // Synchronisers and the vblank edge register keep running even while paused
  always_ff @(posedge clkm_20MHZ or negedge RESET_n)
    if (!RESET_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      vblank_q <= 1'b0;
    end else begin
      sync1_q  <= joy_in;
      sync2_q  <= sync1_q;
      vblank_q <= vblank;
    end
  assign frame_tick = vblank & ~vblank_q & ~pause;
  // Per-bit debounce: count consecutive disagreeing cycles, adopt the input after DEB_CYC of them
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 9; i++) begin
      cnt_d[i] = (sync2_q[i] == deb_q[i] || cnt_q[i] == DEB_CYC - 16'd1) ? 16'd0 : cnt_q[i] + 16'd1;
      deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == DEB_CYC - 16'd1) ? sync2_q[i] : deb_q[i];
    end
  end
  // Debounce state freezes while paused
  always_ff @(posedge clkm_20MHZ or negedge RESET_n)
    if (!RESET_n) begin
      deb_q <= '0;
      cnt_q <= '{default: '0};
    end else if (!pause) begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  assign turbo_wrap = tcnt_q == TURBO_FRAMES - 3'd1;
  // Turbo frame counter and phase; releasing shoot rearms so the next press fires at once
  always_comb begin
    tcnt_d  = !deb_q[4] ? 3'd0 : !frame_tick ? tcnt_q : turbo_wrap ? 3'd0 : tcnt_q + 3'd1;
    phase_d = !deb_q[4] ? 1'b1 : (frame_tick & turbo_wrap) ? ~phase_q : phase_q;
  end
  // Turbo state freezes while paused
  always_ff @(posedge clkm_20MHZ or negedge RESET_n)
    if (!RESET_n) begin
      tcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (!pause) begin
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  // Active-low outputs; opposing directions pressed together release both
  always_comb begin
    ctl_d[0]   = ~(deb_q[0] & ~deb_q[1]);
    ctl_d[1]   = ~(deb_q[1] & ~deb_q[0]);
    ctl_d[2]   = ~(deb_q[2] & ~deb_q[3]);
    ctl_d[3]   = ~(deb_q[3] & ~deb_q[2]);
    ctl_d[4]   = turbo_en ? ~(deb_q[4] & phase_q) : ~deb_q[4];
    ctl_d[7:5] = ~deb_q[7:5];
  end
  // Output register holds its last value while paused
  always_ff @(posedge clkm_20MHZ or negedge RESET_n)
    if (!RESET_n) ctl_q <= 8'hFF;
    else if (!pause) ctl_q <= ctl_d;
  // Coin FSM: one frame-timed pulse per press, then a gap, then wait for release
  always_ff @(posedge clkm_20MHZ or negedge RESET_n)
    if (!RESET_n) begin
      st_q        <= IDLE;
      fcnt_q      <= '0;
      coin_q      <= 1'b1;
      coin_prev_q <= 1'b0;
    end else if (!pause) begin
      coin_prev_q <= deb_q[8];
      case (st_q)
        IDLE:
          if (deb_q[8] & ~coin_prev_q) begin
            st_q   <= PULSE;
            fcnt_q <= '0;
            coin_q <= 1'b0;
          end
        PULSE:
          if (frame_tick) begin
            if (fcnt_q == COIN_FRAMES - 4'd1) begin
              st_q   <= GAP;
              fcnt_q <= '0;
              coin_q <= 1'b1;
            end else fcnt_q <= fcnt_q + 4'd1;
          end
        GAP:
          if (frame_tick) begin
            if (fcnt_q == COIN_GAP - 4'd1) begin
              st_q   <= deb_q[8] ? WAIT_REL : IDLE;
              fcnt_q <= '0;
            end else fcnt_q <= fcnt_q + 4'd1;
          end
        WAIT_REL:
          if (!deb_q[8]) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  assign CONTROLS  = {coin_q, ctl_q};
  assign coin_busy = st_q != IDLE;
endmodule
